// File: rtl/vseq_pkg.sv
// Shared definitions for the multi-cycle vector execution unit:
// op encodings, FSM states and NZCV bit positions.
package vseq_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_AND    = 3'b010;
    localparam logic [2:0] OP_ORR    = 3'b011;
    localparam logic [2:0] OP_MOV    = 3'b100;
    localparam logic [2:0] OP_REDSUM = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/vlane_alu.sv
// One combinational element lane: result and NZCV for a single element pair.
// For REDSUM the lane passes vn through so the top can sum it.
module vlane_alu
    import vseq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_res,
    output logic [3:0]   o_nzcv
);

    logic [W:0] w_add;
    logic [W:0] w_sub;

    assign w_add = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_res  = '0;
        o_nzcv = '0;
        case (i_op)
            OP_ADD: begin
                o_res          = w_add[W-1:0];
                o_nzcv[FLAG_C] = w_add[W];
                o_nzcv[FLAG_V] = (i_a[W-1] == i_b[W-1]) && (w_add[W-1] != i_a[W-1]);
            end
            OP_SUB: begin
                // C is "no borrow": set when vn >= vm
                o_res          = w_sub[W-1:0];
                o_nzcv[FLAG_C] = ~w_sub[W];
                o_nzcv[FLAG_V] = (i_a[W-1] != i_b[W-1]) && (w_sub[W-1] != i_a[W-1]);
            end
            OP_AND:    o_res = i_a & i_b;
            OP_ORR:    o_res = i_a | i_b;
            OP_MOV:    o_res = i_b;
            OP_REDSUM: o_res = i_a;
            default:   o_res = '0;
        endcase
        o_nzcv[FLAG_N] = o_res[W-1];
        o_nzcv[FLAG_Z] = (o_res == '0);
    end

endmodule

// File: rtl/vseq_unit.sv
// Multi-cycle vector unit: private register file, LANES elements per EXEC
// cycle, start/ready/done handshake plus scalar load/read side port.
module vseq_unit
    import vseq_pkg::*;
#(
    parameter int W     = 32,
    parameter int LANES = 2,
    parameter int MAXVL = 8,
    parameter int NVREG = 16,
    parameter int RW    = $clog2(NVREG),
    parameter int VW    = $clog2(MAXVL + 1),
    parameter int IW    = $clog2(MAXVL)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [2:0]    i_op,
    input  logic [RW-1:0] i_vd,
    input  logic [RW-1:0] i_vn,
    input  logic [RW-1:0] i_vm,
    input  logic [VW-1:0] i_vl,
    output logic          o_ready,
    output logic          o_done,
    output logic [W-1:0]  o_scalar_result,
    output logic [3:0]    o_flags,
    input  logic          i_ld_we,
    input  logic [RW-1:0] i_ld_reg,
    input  logic [IW-1:0] i_ld_idx,
    input  logic [W-1:0]  i_ld_data,
    input  logic [RW-1:0] i_rd_reg,
    input  logic [IW-1:0] i_rd_idx,
    output logic [W-1:0]  o_rd_data
);

    state_t        r_state, w_state_nxt;
    logic [2:0]    r_op;
    logic [RW-1:0] r_vd, r_vn, r_vm;
    logic [VW-1:0] r_vl, r_idx;
    logic [W-1:0]  r_acc;
    logic          r_allz;
    logic [W-1:0]  r_scalar;
    logic [3:0]    r_flags;
    logic [W-1:0]  r_vreg [NVREG][MAXVL];

    logic [VW-1:0]                w_vl_clamp;
    logic                         w_last;
    logic                         w_wr;
    logic [LANES-1:0]             w_ein;
    logic [LANES-1:0][IW-1:0]     w_eidx;
    logic [LANES-1:0][W-1:0]      w_a, w_b, w_res;
    logic [LANES-1:0][3:0]        w_nzcv;
    logic [W-1:0]                 w_sum;
    logic                         w_allz;
    logic [3:0]                   w_lastf;
    logic [3:0]                   w_flags_fin;

    assign w_vl_clamp = (i_vl > VW'(MAXVL)) ? VW'(MAXVL) : i_vl;
    assign w_last     = (int'(r_idx) + LANES) >= int'(r_vl);
    assign w_wr       = (r_op <= OP_MOV);

    assign o_ready         = (r_state == S_IDLE);
    assign o_done          = (r_state == S_DONE);
    assign o_scalar_result = r_scalar;
    assign o_flags         = r_flags;
    assign o_rd_data       = r_vreg[i_rd_reg][i_rd_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = (w_vl_clamp == '0) ? S_DONE : S_EXEC;
            S_EXEC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Element indices for this beat; out-of-range lanes read element 0 harmlessly.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_ein[l]  = (int'(r_idx) + l) < int'(r_vl);
            w_eidx[l] = w_ein[l] ? IW'(int'(r_idx) + l) : '0;
            w_a[l]    = r_vreg[r_vn][w_eidx[l]];
            w_b[l]    = r_vreg[r_vm][w_eidx[l]];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        vlane_alu #(.W(W)) u_lane (
            .i_op   (r_op),
            .i_a    (w_a[g]),
            .i_b    (w_b[g]),
            .o_res  (w_res[g]),
            .o_nzcv (w_nzcv[g])
        );
    end

    always_comb begin
        w_sum   = r_acc;
        w_allz  = r_allz;
        w_lastf = '0;
        for (int l = 0; l < LANES; l++) begin
            if (w_ein[l]) begin
                w_sum  = w_sum + w_a[l];
                w_allz = w_allz & w_nzcv[l][FLAG_Z];
                if ((int'(r_idx) + l) == (int'(r_vl) - 1)) w_lastf = w_nzcv[l];
            end
        end
        w_flags_fin = '0;
        if (r_op == OP_REDSUM) begin
            w_flags_fin[FLAG_N] = w_sum[W-1];
            w_flags_fin[FLAG_Z] = (w_sum == '0);
        end else begin
            w_flags_fin         = w_lastf;
            w_flags_fin[FLAG_Z] = w_allz;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op     <= OP_ADD;
            r_vd     <= '0;
            r_vn     <= '0;
            r_vm     <= '0;
            r_vl     <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_allz   <= 1'b1;
            r_scalar <= '0;
            r_flags  <= '0;
            for (int r = 0; r < NVREG; r++)
                for (int e = 0; e < MAXVL; e++)
                    r_vreg[r][e] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Load lands before EXEC's first read, so a same-cycle start sees it
                    if (i_ld_we) r_vreg[i_ld_reg][i_ld_idx] <= i_ld_data;
                    if (i_start) begin
                        r_op   <= i_op;
                        r_vd   <= i_vd;
                        r_vn   <= i_vn;
                        r_vm   <= i_vm;
                        r_vl   <= w_vl_clamp;
                        r_idx  <= '0;
                        r_acc  <= '0;
                        r_allz <= 1'b1;
                        if (w_vl_clamp == '0) begin
                            r_flags  <= 4'b0100;
                            r_scalar <= '0;
                        end
                    end
                end
                S_EXEC: begin
                    for (int l = 0; l < LANES; l++)
                        if (w_ein[l] && w_wr) r_vreg[r_vd][w_eidx[l]] <= w_res[l];
                    r_acc  <= w_sum;
                    r_allz <= w_allz;
                    r_idx  <= r_idx + VW'(LANES);
                    if (w_last) begin
                        r_flags <= w_flags_fin;
                        if (r_op == OP_REDSUM) r_scalar <= w_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vseq_unit.sv
// Directed bench for vseq_unit (W=32, LANES=2, MAXVL=8, NVREG=16).
module tb_vseq_unit;
    import vseq_pkg::*;

    localparam int RW = 4;
    localparam int VW = 4;
    localparam int IW = 3;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [2:0]    i_op = 3'b000;
    logic [RW-1:0] i_vd = '0, i_vn = '0, i_vm = '0;
    logic [VW-1:0] i_vl = '0;
    logic          o_ready, o_done;
    logic [31:0]   o_scalar_result;
    logic [3:0]    o_flags;
    logic          i_ld_we = 1'b0;
    logic [RW-1:0] i_ld_reg = '0;
    logic [IW-1:0] i_ld_idx = '0;
    logic [31:0]   i_ld_data = '0;
    logic [RW-1:0] i_rd_reg = '0;
    logic [IW-1:0] i_rd_idx = '0;
    logic [31:0]   o_rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    vseq_unit u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
        .i_vd(i_vd), .i_vn(i_vn), .i_vm(i_vm), .i_vl(i_vl),
        .o_ready(o_ready), .o_done(o_done), .o_scalar_result(o_scalar_result),
        .o_flags(o_flags), .i_ld_we(i_ld_we), .i_ld_reg(i_ld_reg),
        .i_ld_idx(i_ld_idx), .i_ld_data(i_ld_data), .i_rd_reg(i_rd_reg),
        .i_rd_idx(i_rd_idx), .o_rd_data(o_rd_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ld(input int r, input int e, input logic [31:0] d);
        @(negedge i_clk);
        i_ld_we = 1'b1; i_ld_reg = RW'(r); i_ld_idx = IW'(e); i_ld_data = d;
        @(negedge i_clk);
        i_ld_we = 1'b0;
    endtask

    task automatic rd(input int r, input int e, output logic [31:0] d);
        i_rd_reg = RW'(r); i_rd_idx = IW'(e);
        #1 d = o_rd_data;
    endtask

    task automatic chk_el(input string tag, input int r, input int e, input logic [31:0] exp);
        logic [31:0] d;
        rd(r, e, d);
        chk(tag, d, exp);
    endtask

    // Issue one op; lat = cycle offset of done relative to the start edge (-1 on timeout).
    task automatic run_op(input logic [2:0] op, input int vd, input int vn, input int vm,
                          input int vl, input bit noise, output int lat);
        @(negedge i_clk);
        i_start = 1'b1; i_op = op;
        i_vd = RW'(vd); i_vn = RW'(vn); i_vm = RW'(vm); i_vl = VW'(vl);
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (o_done) begin
                lat = n + 1;
                break;
            end
            if (noise) begin
                i_start = 1'b1; i_op = OP_SUB; i_vd = RW'(2); i_vl = VW'(8);
                i_ld_we = 1'b1; i_ld_reg = RW'(2); i_ld_idx = '0; i_ld_data = 32'hDEAD;
            end
            @(negedge i_clk);
            i_start = 1'b0; i_ld_we = 1'b0;
        end
        if (lat > 0) begin
            @(negedge i_clk);
            chk("ready_after_done", {31'b0, o_ready}, 32'd1);
            chk("done_one_cycle", {31'b0, o_done}, 32'd0);
        end
    endtask

    initial begin
        int lat;
        logic [31:0] d;

        #12;
        chk("rst_ready", {31'b0, o_ready}, 32'd1);
        chk("rst_done", {31'b0, o_done}, 32'd0);
        chk("rst_flags", {28'b0, o_flags}, 32'd0);
        chk("rst_scalar", o_scalar_result, 32'd0);
        chk_el("rst_elem", 5, 3, 32'd0);
        i_rst_n = 1'b1;

        for (int e = 0; e < 8; e++) begin
            ld(1, e, 32'(e + 1));
            ld(2, e, 32'(10 * (e + 1)));
        end

        run_op(OP_ADD, 3, 1, 2, 8, 1'b0, lat);
        chk("add_latency", 32'(lat), 32'd5);
        for (int e = 0; e < 8; e++) chk_el("add_v3", 3, e, 32'(11 * (e + 1)));
        chk("add_flags", {28'b0, o_flags}, 32'h0);

        for (int e = 5; e < 8; e++) ld(4, e, 32'h55);
        run_op(OP_SUB, 4, 1, 1, 5, 1'b0, lat);
        chk("sub_latency", 32'(lat), 32'd4);
        for (int e = 0; e < 5; e++) chk_el("sub_v4_zero", 4, e, 32'd0);
        for (int e = 5; e < 8; e++) chk_el("sub_v4_keep", 4, e, 32'h55);
        chk("sub_flags", {28'b0, o_flags}, 32'h6);

        run_op(OP_REDSUM, 0, 1, 0, 7, 1'b0, lat);
        chk("redsum_latency", 32'(lat), 32'd5);
        chk("redsum_result", o_scalar_result, 32'd28);
        chk("redsum_flags", {28'b0, o_flags}, 32'h0);

        ld(5, 7, 32'h7FFF_FFFF);
        ld(6, 7, 32'h1);
        run_op(OP_ADD, 7, 5, 6, 8, 1'b0, lat);
        chk_el("ovf_elem", 7, 7, 32'h8000_0000);
        chk("ovf_flags", {28'b0, o_flags}, 32'h9);

        run_op(OP_ADD, 1, 1, 1, 8, 1'b0, lat);
        for (int e = 0; e < 8; e++) chk_el("alias_v1", 1, e, 32'(2 * (e + 1)));

        ld(8, 0, 32'h77);
        run_op(OP_ADD, 8, 1, 2, 0, 1'b0, lat);
        chk("vl0_latency", 32'(lat), 32'd1);
        chk_el("vl0_nowrite", 8, 0, 32'h77);
        chk("vl0_flags", {28'b0, o_flags}, 32'h4);
        chk("vl0_scalar", o_scalar_result, 32'd0);

        run_op(OP_ADD, 9, 2, 2, 12, 1'b0, lat);
        chk("clamp_latency", 32'(lat), 32'd5);
        chk_el("clamp_v9_7", 9, 7, 32'd160);

        run_op(OP_ADD, 10, 2, 2, 8, 1'b1, lat);
        chk("noise_latency", 32'(lat), 32'd5);
        chk_el("noise_ld_ignored", 2, 0, 32'd10);
        chk_el("noise_v10_0", 10, 0, 32'd20);

        run_op(OP_REDSUM, 0, 2, 0, 8, 1'b0, lat);
        chk("redsum_v2", o_scalar_result, 32'd360);
        run_op(OP_SUB, 12, 1, 1, 8, 1'b0, lat);
        chk("sub_full_flags", {28'b0, o_flags}, 32'h6);

        @(negedge i_clk);
        i_start = 1'b1; i_op = OP_ADD; i_vd = RW'(11); i_vn = RW'(2); i_vm = RW'(2); i_vl = VW'(8);
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        chk_el("mid_exec_written", 11, 0, 32'd20);
        chk("mid_exec_busy", {31'b0, o_ready}, 32'd0);
        i_rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'b0, o_ready}, 32'd1);
        chk("abort_done", {31'b0, o_done}, 32'd0);
        chk("abort_flags", {28'b0, o_flags}, 32'd0);
        chk("abort_scalar", o_scalar_result, 32'd0);
        chk_el("abort_v11", 11, 0, 32'd0);
        chk_el("abort_v2", 2, 0, 32'd0);
        chk_el("abort_v1", 1, 7, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("post_abort_ready", {31'b0, o_ready}, 32'd1);
        chk_el("post_abort_v11", 11, 3, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vseq_unit.md
# vseq_unit

Parametrised multi-cycle vector execution unit, the successor to the fixed five-lane single-cycle vector path in the processor datapath. Holds its own vector register file of NVREG registers × MAXVL elements. Executes element-wise or reduction operations on a programmable vector length, processing LANES elements per clock. The core issues one operation through a start/ready/done handshake and loads or reads elements through a scalar side port.

## Interface

Parameters:
- W, 32: element width in bits
- LANES, 2: elements processed per EXEC cycle (1..MAXVL)
- MAXVL, 8: maximum vector length, elements per register
- NVREG, 16: number of vector registers (index width RW = clog2(NVREG))

Ports (VW = clog2(MAXVL+1), IW = clog2(MAXVL)):
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  issue request; sampled only when ready=1
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV (vd=vm), 101 REDSUM (sum of vn)
- vd, vn, vm  in  RW each  destination and source vector registers
- vl  in  VW  vector length; values above MAXVL are clamped to MAXVL
- ready  out  1  unit is IDLE and accepts start or ld_we
- done  out  1  one-cycle completion pulse
- scalar_result  out  W  REDSUM result, held until the next completion
- flags  out  4  NZCV of the last completed operation
- ld_we, ld_reg (RW), ld_idx (IW), ld_data (W)  in  element write port, honoured only when ready=1
- rd_reg (RW), rd_idx (IW)  in, rd_data (W)  out  combinational element read

## Operation

- States are IDLE, EXEC and DONE.
- IDLE:
  - ready=1.
  - start=1 latches op, vd, vn, vm and clamped vl, and sets idx=0.
  - Goes to EXEC if vl>0, otherwise to DONE with no register writes.
- EXEC: each cycle handles elements idx..idx+LANES-1 that are below vl.
  - Element ops write vd[e] = f(vn[e], vm[e]).
  - REDSUM adds the in-range vn elements to the accumulator; the accumulator is cleared on start.
  - idx advances by LANES. Goes to DONE when idx+LANES ≥ vl.
- DONE: done=1 for one cycle, results and flags are updated, then the unit returns to IDLE.
- Aliasing (vd equal to vn or vm): each element is read and written in the same cycle. The read returns the pre-write value, so aliasing is always safe.
- Arithmetic:
  - All arithmetic is modulo 2^W.
  - SUB computes vn−vm; C is NOT borrow (ARM convention).
  - The REDSUM accumulator wraps.
- Flags, element ops:
  - Z=1 iff all vl results are zero.
  - N = bit W−1 of element vl−1.
  - C and V come from element vl−1 for ADD/SUB, and are 0 otherwise.
- Flags, REDSUM: N and Z come from the sum; C=V=0; scalar_result = sum.
- vl=0: flags=0100 (Z set), scalar_result=0.
- While ready=0, start and ld_we are ignored.
- If ld_we and start are asserted in the same IDLE cycle, the load is applied first and the operation sees the loaded value.

## Timing

- Reset values: state IDLE, ready=1, done=0, scalar_result=0, flags=0, all vector elements 0, idx=0.
- With start sampled at edge k and C = ceil(vl/LANES):
  - EXEC covers cycles k+1..k+C.
  - done is high in cycle k+C+1.
  - ready returns in cycle k+C+2.
  - When vl=0, done is high in cycle k+1.
- vd writes take effect at the edge ending each EXEC cycle.
- scalar_result and flags change at the edge entering DONE.
- rd_data is combinational from the current array contents.
- Reset asserted mid-EXEC aborts the operation at once: every output and register returns to its reset value, including elements already written.

## Structure

- Package vseq_pkg holds:
  - the op encoding localparams (OP_ADD … OP_REDSUM)
  - the state enum (S_IDLE, S_EXEC, S_DONE)
  - the NZCV bit positions
- Sub-module vlane_alu is combinational: one W-bit lane computing result and NZCV for op. It is instantiated LANES times.
- The top level holds the FSM, idx counter, accumulator, register array and the combined flag logic.

## Test plan

- Reset, then load v1=[1..8] and v2=[10,20..80]; ADD v3=v1+v2 with vl=8, LANES=2 → done at cycle start+5, v3=[11,22..88], flags=0000.
- SUB v4=v1−v1 with vl=5 → v4[0..4]=0, v4[5..7] unchanged, Z=1, C=1.
- REDSUM v1 with vl=7 (odd vl, partial final beat) → scalar_result=28; ADD of 0x7FFFFFFF+1 in element vl−1 → N=1, V=1.
- Aliased ADD v1=v1+v1 with vl=8 → v1=[2,4..16]; vl=0 → done at start+1 and no writes; vl=12 → clamped to 8.
- start and ld_we pulsed during EXEC → both ignored; reset asserted mid-EXEC → ready=1, all reads return 0.
